// File: rtl/sdf_pkg.sv
// rtl/sdf_pkg.sv - shared types and depth clamping for the SDF delay line
package sdf_pkg;

  localparam int SDF_WIDTH = 32;

  // One complex sample; "real" is a reserved word, so the parts are re/im.
  typedef struct packed {
    logic [SDF_WIDTH-1:0] re;
    logic [SDF_WIDTH-1:0] im;
  } cplx_t;

  // Map a requested delay onto the legal range 1..max_depth.
  function automatic int unsigned clamp_depth(input int unsigned sel,
                                              input int unsigned max_depth);
    if (sel == 0) begin
      return 1;
    end else if (sel > max_depth) begin
      return max_depth;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/sdf_dly_ram.sv
// rtl/sdf_dly_ram.sv - single-port read-before-write sample RAM with registered read
module sdf_dly_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array: written on every accepted sample, never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // Read register returns the old word at addr; it only loads when the
  // caller wants a genuine delayed sample, so it never shows unwritten RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdf_delay_line.sv
// rtl/sdf_delay_line.sv - stall-tolerant configurable complex delay line (optional SDF_DLY_BYPASS_EN)
import sdf_pkg::*;

module sdf_delay_line #(
  parameter int WIDTH     = SDF_WIDTH,
  parameter int MAX_DEPTH = 128,
  parameter int DEPTH_W   = $clog2(MAX_DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [DEPTH_W-1:0] depth_sel,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   input_real,
  input  logic [WIDTH-1:0]   input_imag,
`ifdef SDF_DLY_BYPASS_EN
  input  logic               bypass,
`endif
  output logic [WIDTH-1:0]   out_real,
  output logic [WIDTH-1:0]   out_imag,
  output logic               out_valid,
  output logic               primed,
  output logic               cfg_err
);

  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(1);
  localparam logic [AW-1:0]      ONE_A = AW'(1);

  logic [DEPTH_W-1:0] depth_q, depth_d, depth_c;
  logic [DEPTH_W-1:0] fill_q, fill_d;
  logic [AW-1:0]      ptr_q, ptr_d;
  logic               valid_q, valid_d;
  logic               primed_q, primed_d;
  logic               err_q, err_d;
  logic               err_c, reconfig, accept, full, rd_en;
  logic [2*WIDTH-1:0] ram_rdata;

`ifdef SDF_DLY_BYPASS_EN
  logic               byp_q, sel_q;
  logic [2*WIDTH-1:0] byp_data_q;
`endif

  // Clamp the requested depth and flag out-of-range requests.
  always_comb begin
    depth_c = DEPTH_W'(clamp_depth(32'(depth_sel), MAX_DEPTH));
    err_c   = (depth_sel == '0) || (depth_sel > MAX_D);
  end

  // A depth change (or leaving bypass) restarts the line and eats the sample.
`ifdef SDF_DLY_BYPASS_EN
  assign reconfig = (depth_c != depth_q) || (byp_q && !bypass);
  assign accept   = in_valid && !reconfig && !bypass;
`else
  assign reconfig = (depth_c != depth_q);
  assign accept   = in_valid && !reconfig;
`endif
  assign full  = (fill_q == depth_q);
  assign rd_en = accept && full;

  // Next-state for pointer, fill level and status flags.
  always_comb begin
    depth_d  = depth_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    valid_d  = 1'b0;
    primed_d = primed_q;
    err_d    = err_c;
`ifdef SDF_DLY_BYPASS_EN
    if (bypass) begin
      depth_d  = depth_c;
      valid_d  = in_valid;
      primed_d = 1'b0;
    end else
`endif
    if (reconfig) begin
      depth_d  = depth_c;
      ptr_d    = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else if (accept) begin
      ptr_d    = (DEPTH_W'(ptr_q) == depth_q - ONE_D) ? '0 : ptr_q + ONE_A;
      fill_d   = full ? fill_q : fill_q + ONE_D;
      valid_d  = full;
      primed_d = (fill_d == depth_q);
    end
  end

  // Control registers; reset samples the clamped depth directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q  <= depth_c;
      ptr_q    <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      primed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      depth_q  <= depth_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      primed_q <= primed_d;
      err_q    <= err_d;
    end
  end

  // The RAM read register doubles as the output data register.
  sdf_dly_ram #(
    .DW    (2 * WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (accept),
    .re_i    (rd_en),
    .addr_i  (ptr_q),
    .wdata_i ({input_real, input_imag}),
    .rdata_o (ram_rdata)
  );

`ifdef SDF_DLY_BYPASS_EN
  // Bypass path: latency-1 copy of the input, held until the RAM path speaks again.
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_q      <= 1'b0;
      sel_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q <= bypass;
      if (bypass) begin
        byp_data_q <= {input_real, input_imag};
        sel_q      <= 1'b1;
      end else if (rd_en) begin
        sel_q <= 1'b0;
      end
    end
  end

  assign out_real = sel_q ? byp_data_q[2*WIDTH-1:WIDTH] : ram_rdata[2*WIDTH-1:WIDTH];
  assign out_imag = sel_q ? byp_data_q[WIDTH-1:0]       : ram_rdata[WIDTH-1:0];
`else
  assign out_real = ram_rdata[2*WIDTH-1:WIDTH];
  assign out_imag = ram_rdata[WIDTH-1:0];
`endif

  assign out_valid = valid_q;
  assign primed    = primed_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_sdf_delay_line.sv
// tb/tb_sdf_delay_line.sv - self-checking bench for sdf_delay_line
module tb_sdf_delay_line;

  localparam int W  = 32;
  localparam int MD = 128;
  localparam int DW = $clog2(MD) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] depth_sel;
  logic          in_valid;
  logic [W-1:0]  input_real, input_imag;
  logic [W-1:0]  out_real, out_imag;
  logic          out_valid, primed, cfg_err;
`ifdef SDF_DLY_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  sdf_delay_line #(.WIDTH(W), .MAX_DEPTH(MD)) dut (
    .clock      (clock),
    .reset      (reset),
    .depth_sel  (depth_sel),
    .in_valid   (in_valid),
    .input_real (input_real),
    .input_imag (input_imag),
`ifdef SDF_DLY_BYPASS_EN
    .bypass     (bypass),
`endif
    .out_real   (out_real),
    .out_imag   (out_imag),
    .out_valid  (out_valid),
    .primed     (primed),
    .cfg_err    (cfg_err)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of accepted samples per configuration.
  logic [63:0] hist[$];
  int          depth_m   = 1;
  logic [W-1:0] exp_re   = '0;
  logic [W-1:0] exp_im   = '0;
  logic        exp_valid = 1'b0;
  logic        exp_primed = 1'b0;
  logic        exp_err   = 1'b0;
  int unsigned got[$];
  int unsigned exp_list[$];

  function automatic int m_clamp(input int s);
    if (s < 1) return 1;
    if (s > MD) return MD;
    return s;
  endfunction

  always @(posedge clock) begin
    int dc;
    logic [63:0] old;
    dc = m_clamp(int'(depth_sel));
    if (reset) begin
      depth_m = dc; hist.delete();
      exp_re = '0; exp_im = '0; exp_valid = 0; exp_primed = 0; exp_err = 0;
    end else begin
      exp_err   = (depth_sel == 0) || (int'(depth_sel) > MD);
      exp_valid = 0;
      if (dc != depth_m) begin
        depth_m = dc; hist.delete(); exp_primed = 0;
      end else if (in_valid) begin
        if (hist.size() == depth_m) begin
          old = hist.pop_front();
          exp_re = old[63:32]; exp_im = old[31:0]; exp_valid = 1;
        end
        hist.push_back({input_real, input_imag});
        exp_primed = (hist.size() == depth_m);
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_valid));
    chk("out_real",  64'(out_real),  64'(exp_re));
    chk("out_imag",  64'(out_imag),  64'(exp_im));
    chk("primed",    64'(primed),    64'(exp_primed));
    chk("cfg_err",   64'(cfg_err),   64'(exp_err));
    if (out_valid === 1'b1) got.push_back(out_real);
  end

  task automatic send(input int v);
    in_valid   = 1'b1;
    input_real = 32'(v);
    input_imag = 32'(v + 1000);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int d);
    depth_sel = DW'(d);
    in_valid  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    got.delete();
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < got.size(); i++)
      chk(name, 64'(got[i]), 64'(exp_list[i]));
  endtask

  initial begin
    reset = 1'b1; depth_sel = DW'(4); in_valid = 1'b0;
    input_real = '0; input_imag = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_real",   64'(out_real),  64'd0);
    chk("rst_primed", 64'(primed),    64'd0);
    chk("rst_err",    64'(cfg_err),   64'd0);

    // depth 4, back-to-back stream
    got.delete();
    for (int i = 1; i <= 10; i++) begin
      send(i);
      if (i == 5) begin
        chk("t1_first_real", 64'(out_real), 64'd1);
        chk("t1_first_imag", 64'(out_imag), 64'd1001);
      end
    end
    idle(3);
    exp_list = '{1, 2, 3, 4, 5, 6};
    check_got("t1_out");

    // depth 4, alternating valid
    do_reset(4);
    for (int i = 1; i <= 12; i++) begin
      send(i);
      idle(1);
    end
    exp_list = '{1, 2, 3, 4, 5, 6, 7, 8};
    check_got("t2_out");

    // depth 1
    do_reset(1);
    send(7);
    chk("t3_primed", 64'(primed), 64'd1);
    send(8);
    send(9);
    idle(2);
    exp_list = '{7, 8};
    check_got("t3_out");

    // reconfigure 4 -> 8 on sample 9
    do_reset(4);
    for (int i = 1; i <= 20; i++) begin
      if (i == 9) depth_sel = DW'(8);
      send(i);
      if (i == 9) begin
        chk("t4_primed_clr", 64'(primed),    64'd0);
        chk("t4_hold",       64'(out_real),  64'd4);
        chk("t4_valid_clr",  64'(out_valid), 64'd0);
      end
    end
    idle(2);
    exp_list = '{1, 2, 3, 4, 10, 11, 12};
    check_got("t4_out");

    // out-of-range depths
    do_reset(0);
    send(1);
    chk("t5_err_zero", 64'(cfg_err), 64'd1);
    send(2);
    send(3);
    idle(1);
    exp_list = '{1, 2};
    check_got("t5a_out");
    depth_sel = DW'(200);
    idle(1);
    chk("t5_err_big", 64'(cfg_err), 64'd1);
    got.delete();
    for (int i = 1; i <= 130; i++) send(i);
    idle(2);
    chk("t5_primed", 64'(primed), 64'd1);
    exp_list = '{1, 2};
    check_got("t5b_out");

    // reset mid-stream
    do_reset(4);
    for (int i = 1; i <= 5; i++) send(i);
    reset = 1'b1;
    send(6);
    reset = 1'b0;
    in_valid = 1'b0;
    chk("t6_valid",  64'(out_valid), 64'd0);
    chk("t6_real",   64'(out_real),  64'd0);
    chk("t6_imag",   64'(out_imag),  64'd0);
    chk("t6_primed", 64'(primed),    64'd0);
    chk("t6_err",    64'(cfg_err),   64'd0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
